result_fifo_reader: RTL and testbench
=====================================

# result_fifo_reader

Read-back end of the pulse sequencer's result path. Captures the single-word result writes produced by the timing controller (DDS reads, SPI results, loop-back data) and buffers them in an internal circular FIFO. Presents them to the bus side through a valid/ready read port. Also reports fill level and a sticky overflow with a saturating drop counter.

## Interface
- RESULT_WIDTH, 32, width of a result word.
- DEPTH_LOG2, 6, log2 of buffer depth (DEPTH = 64 words).
- DROP_WIDTH, 16, width of the dropped-word counter.

- clock  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- result_data  in  RESULT_WIDTH  result word; valid in the first cycle result_wr_req is high.
- result_wr_req  in  1  write request; one word is written per rising edge (low→high).
- clear  in  1  synchronous flush of buffer and status.
- bus_rd_data  out  RESULT_WIDTH  head word; 0 when bus_rd_valid is low.
- bus_rd_valid  out  1  buffer non-empty.
- bus_rd_ready  in  1  consumer accepts head word.
- fill_count  out  DEPTH_LOG2+1  words currently stored (0..DEPTH).
- full  out  1  fill_count == DEPTH.
- overflow  out  1  sticky; a word was dropped because the buffer was full.
- drop_count  out  DROP_WIDTH  dropped words, saturating at all-ones.

## Operation
- Edge detect: register wr_req_d <= result_wr_req. push = result_wr_req & ~wr_req_d. A request held high for N cycles yields exactly one word. Back-to-back words need at least one low cycle between them.
- Storage: DEPTH x RESULT_WIDTH array, wr_ptr and rd_ptr of DEPTH_LOG2 bits, both wrapping modulo DEPTH, plus a separate count register (fill_count).
- pop = bus_rd_valid & bus_rd_ready.
- bus_rd_valid = (fill_count != 0). bus_rd_data = mem[rd_ptr] when valid, else 0. The read is combinational from the registered pointer.
- Push accepted when: fill_count < DEPTH, or a pop occurs in the same cycle. An accepted push writes mem[wr_ptr] and increments wr_ptr.
- Push when full with no pop: word discarded, overflow <= 1, drop_count += 1 (holds at max). Buffer contents and pointers are unchanged.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop: unchanged; both pointers advance.
- Pop when empty cannot occur, because valid is low.
- clear:
  - Next edge: wr_ptr, rd_ptr, fill_count, overflow and drop_count all go to 0.
  - A push or pop in the clear cycle is ignored; clear wins.
  - wr_req_d still updates, so a request that rose in the clear cycle is not re-sampled later.

## Timing
- Reset (resetn low, asynchronous):
  - bus_rd_valid=0, bus_rd_data=0, fill_count=0, full=0, overflow=0, drop_count=0.
  - Pointers are 0. wr_req_d=1, so a request already high at reset release is not counted.
  - Memory contents are not reset.
- Write latency: result_wr_req rises in cycle N → word stored at the end of N → bus_rd_valid=1 with that word in cycle N+1.
- Read: a word accepted at the edge ending cycle M. The next word, or valid=0, is visible in cycle M+1. Sustained throughput is 1 word/cycle when the buffer is non-empty.
- full and overflow update at the same edge as fill_count.
- Reset asserted mid-stream: all buffered words are lost immediately; outputs go to reset values without waiting for a clock.

## Test plan
- Single word: drive data 0xDEADBEEF with result_wr_req high for 1 cycle; ready=1 → valid high for exactly 1 cycle with 0xDEADBEEF; fill_count goes 0→1→0.
- Held request: result_wr_req high for 10 cycles, data 0x1 → fill_count=1 and exactly one word read.
- Fill and overflow: 64 pulses of data i=0..63 with ready=0 → full=1, fill_count=64. A 65th pulse → overflow=1, drop_count=1. Then drain with ready=1 → reads 0..63 in order; overflow stays 1.
- Full with concurrent push/pop: at fill_count=64, pulse data 0xAA in the same cycle as a pop → fill_count stays 64, overflow stays 0, 0xAA is read last.
- Wrap: 200 interleaved pushes and pops at varying fill levels → output order matches input order, fill_count is never wrong.
- Clear and reset: load 5 words, assert clear together with a new pulse → fill_count=0, valid=0, overflow=0, and the new word is absent. Load 3 words, drop resetn asynchronously mid-cycle → valid and fill_count are 0 before the next edge.

Source files
------------

// File: rtl/result_fifo_reader.sv
// Result read-back FIFO: captures one word per rising edge of the write request
// and serves it through a valid/ready port with fill level and overflow status.
module result_fifo_reader #(
  parameter int RESULT_WIDTH = 32,
  parameter int DEPTH_LOG2   = 6,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [RESULT_WIDTH-1:0] result_data,
  input  logic                    result_wr_req,
  input  logic                    clear,
  output logic [RESULT_WIDTH-1:0] bus_rd_data,
  output logic                    bus_rd_valid,
  input  logic                    bus_rd_ready,
  output logic [DEPTH_LOG2:0]     fill_count,
  output logic                    full,
  output logic                    overflow,
  output logic [DROP_WIDTH-1:0]   drop_count
);

  localparam int                     DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]    DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]    CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DROP_WIDTH-1:0]  DROP_ONE  = {{(DROP_WIDTH-1){1'b0}}, 1'b1};

  logic [RESULT_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [DROP_WIDTH-1:0]   drop_q, drop_d;
  logic                    wr_req_q;

  logic push, pop, is_full, accept, discard;

  assign push    = result_wr_req & ~wr_req_q;
  assign is_full = (count_q == DEPTH_CNT);
  assign pop     = bus_rd_valid & bus_rd_ready;
  // A full buffer still takes a word when the head leaves in the same cycle.
  assign accept  = push & (~is_full | pop);
  assign discard = push & is_full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({accept, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (discard) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_ONE;
      end
    end
  end

  // Request history resets high so a request already asserted at release is ignored.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      wr_req_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      wr_req_q <= result_wr_req;
    end
  end

  always_ff @(posedge clock) begin
    if (accept && !clear) mem_q[wr_ptr_q] <= result_data;
  end

  assign bus_rd_valid = (count_q != '0);
  assign bus_rd_data  = bus_rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fill_count   = count_q;
  assign full         = is_full;
  assign overflow     = ovf_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_result_fifo_reader.sv
// Randomized and directed bench for result_fifo_reader against a queue-based model.
module tb_result_fifo_reader;
  localparam int RW = 32;
  localparam int DL = 6;
  localparam int DW = 4;
  localparam int DEPTH = 64;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [RW-1:0] result_data = '0;
  logic          result_wr_req = 1'b0;
  logic          clear = 1'b0;
  logic          bus_rd_ready = 1'b0;
  logic [RW-1:0] bus_rd_data;
  logic          bus_rd_valid;
  logic [DL:0]   fill_count;
  logic          full;
  logic          overflow;
  logic [DW-1:0] drop_count;

  int total = 0;
  int bad = 0;

  result_fifo_reader #(.RESULT_WIDTH(RW), .DEPTH_LOG2(DL), .DROP_WIDTH(DW)) dut (
    .clock(clock), .resetn(resetn), .result_data(result_data),
    .result_wr_req(result_wr_req), .clear(clear), .bus_rd_data(bus_rd_data),
    .bus_rd_valid(bus_rd_valid), .bus_rd_ready(bus_rd_ready),
    .fill_count(fill_count), .full(full), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Reference model: the buffer is just an ordered queue of words.
  logic [RW-1:0] mq[$];
  bit            m_prev = 1'b1;
  bit            m_ovf = 1'b0;
  int            m_drops = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_prev  = 1'b1;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      bit p, r;
      p = result_wr_req && !m_prev;
      m_prev = result_wr_req;
      if (clear) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
      end else begin
        r = (mq.size() != 0) && bus_rd_ready;
        if (p) begin
          if (mq.size() < DEPTH || r) mq.push_back(result_data);
          else begin
            m_ovf = 1'b1;
            if (m_drops < (1 << DW) - 1) m_drops++;
          end
        end
        if (r) void'(mq.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [RW-1:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : '0;
    chk("valid", 64'(bus_rd_valid), 64'(mq.size() != 0));
    chk("data", 64'(bus_rd_data), 64'(exp_data));
    chk("fill", 64'(fill_count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("ovf", 64'(overflow), 64'(m_ovf));
    chk("drops", 64'(drop_count), 64'(m_drops));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [RW-1:0] d);
    result_data = d;
    result_wr_req = 1'b1;
    tick();
    result_wr_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RW-1:0] last;
    // Request held high across reset release must not produce a word.
    result_wr_req = 1'b1;
    #1;
    chk("rst_valid", 64'(bus_rd_valid), 64'd0);
    chk("rst_fill", 64'(fill_count), 64'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("held_at_release", 64'(fill_count), 64'd0);
    result_wr_req = 1'b0;
    tick();

    // Single word
    bus_rd_ready = 1'b1;
    result_data = 32'hDEADBEEF;
    result_wr_req = 1'b1;
    tick();
    result_wr_req = 1'b0;
    chk("single_valid", 64'(bus_rd_valid), 64'd1);
    chk("single_data", 64'(bus_rd_data), 64'hDEADBEEF);
    chk("single_fill1", 64'(fill_count), 64'd1);
    tick();
    chk("single_gone", 64'(bus_rd_valid), 64'd0);
    chk("single_fill0", 64'(fill_count), 64'd0);

    // Held request
    bus_rd_ready = 1'b0;
    result_data = 32'h1;
    result_wr_req = 1'b1;
    repeat (10) tick();
    result_wr_req = 1'b0;
    tick();
    chk("held_fill", 64'(fill_count), 64'd1);
    bus_rd_ready = 1'b1;
    tick();
    chk("held_drained", 64'(fill_count), 64'd0);
    bus_rd_ready = 1'b0;

    // Fill, overflow, drop saturation, drain in order
    for (int i = 0; i < DEPTH; i++) pulse(RW'(i));
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_64", 64'(fill_count), 64'd64);
    pulse(32'h99);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("drop_1", 64'(drop_count), 64'd1);
    chk("ovf_fill", 64'(fill_count), 64'd64);
    for (int i = 0; i < 20; i++) pulse(32'h77);
    chk("drop_sat", 64'(drop_count), 64'd15);
    bus_rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 64'(bus_rd_data), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(bus_rd_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    bus_rd_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_ovf", 64'(overflow), 64'd0);
    chk("clear_drop", 64'(drop_count), 64'd0);

    // Full with concurrent push and pop
    for (int i = 0; i < DEPTH; i++) pulse(RW'(100 + i));
    bus_rd_ready = 1'b1;
    result_data = 32'hAA;
    result_wr_req = 1'b1;
    tick();
    result_wr_req = 1'b0;
    bus_rd_ready = 1'b0;
    chk("pp_fill", 64'(fill_count), 64'd64);
    chk("pp_ovf", 64'(overflow), 64'd0);
    chk("pp_head", 64'(bus_rd_data), 64'd101);
    bus_rd_ready = 1'b1;
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last = bus_rd_data;
      tick();
    end
    chk("pp_last", 64'(last), 64'hAA);
    chk("pp_empty", 64'(fill_count), 64'd0);

    // Randomized interleaving with varying read pressure
    for (int c = 0; c < 1500; c++) begin
      int bias;
      bias = (c / 150) % 4;
      result_data = $urandom;
      result_wr_req = $urandom_range(0, 1);
      bus_rd_ready = ($urandom_range(0, 3) < bias);
      clear = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear = 1'b0;
    result_wr_req = 1'b0;
    bus_rd_ready = 1'b1;
    repeat (70) tick();
    chk("rand_drained", 64'(fill_count), 64'd0);
    bus_rd_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Clear together with a fresh request
    for (int i = 0; i < 5; i++) pulse(RW'(i + 1));
    chk("clr_load", 64'(fill_count), 64'd5);
    clear = 1'b1;
    result_data = 32'h55;
    result_wr_req = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_fill", 64'(fill_count), 64'd0);
    chk("clr_valid", 64'(bus_rd_valid), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    repeat (2) tick();
    chk("clr_no_resample", 64'(fill_count), 64'd0);
    result_wr_req = 1'b0;
    tick();

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) pulse(RW'(i + 9));
    chk("ar_load", 64'(fill_count), 64'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_valid", 64'(bus_rd_valid), 64'd0);
    chk("ar_fill", 64'(fill_count), 64'd0);
    chk("ar_data", 64'(bus_rd_data), 64'd0);
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    pulse(32'h1234);
    chk("post_reset_word", 64'(bus_rd_data), 64'h1234);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
